// File: rtl/unidade_controle_param.sv
// Parametrised multi-cycle control unit: Run-driven step FSM decoding the IR into
// datapath enables for an NREG-entry register file, plus a retired-instruction counter.
module unidade_controle_param #(
  parameter int DATA_WIDTH = 16,
  parameter int NREG = 8,
  parameter int CNT_W = 8,
  localparam int RW = $clog2(NREG),
  localparam int IW = 3 + 2 * RW
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Run,
  input  logic [IW-1:0]         Instrucao,
  input  logic [DATA_WIDTH-1:0] GRout,
  output logic                  IRin,
  output logic [NREG-1:0]       Rin,
  output logic [NREG-1:0]       Rout,
  output logic                  Ain,
  output logic                  Gin,
  output logic                  Gout,
  output logic                  DINout,
  output logic [1:0]            Ulaop,
  output logic                  Done,
  output logic                  Illegal,
  output logic                  Busy,
  output logic [1:0]            Tstep,
  output logic [CNT_W-1:0]      InstrCount
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3} state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b110;

  state_t          state, state_next;
  logic [2:0]      op;
  logic [RW-1:0]   rx, ry;
  logic [CNT_W-1:0] count;

  assign op = Instrucao[IW-1:IW-3];
  assign rx = Instrucao[2*RW-1:RW];
  assign ry = Instrucao[RW-1:0];
  assign InstrCount = count;

  function automatic logic [NREG-1:0] onehot(input logic [RW-1:0] idx);
    return NREG'(1) << idx;
  endfunction

  function automatic logic [1:0] alu_sel(input logic [2:0] code);
    case (code)
      OP_SUB:  return 2'b01;
      OP_AND:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Reset beats Run; the counter retires on every Done edge, illegal opcodes included.
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (Done) count <= count + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = Run ? T0 : IDLE;
      T0:   state_next = T1;
      T1:   state_next = Done ? (Run ? T0 : IDLE) : T2;
      T2:   state_next = T3;
      T3:   state_next = Run ? T0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    IRin    = 1'b0;
    Rin     = '0;
    Rout    = '0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    DINout  = 1'b0;
    Ulaop   = 2'b00;
    Done    = 1'b0;
    Illegal = 1'b0;
    Busy    = (state != IDLE);
    Tstep   = 2'd0;
    case (state)
      T0: IRin = 1'b1;
      T1: begin
        Tstep = 2'd1;
        case (op)
          OP_MV: begin
            Rin  = onehot(rx);
            Rout = onehot(ry);
            Done = 1'b1;
          end
          OP_MVI: begin
            DINout = 1'b1;
            Rin    = onehot(rx);
            Done   = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            Rout = onehot(rx);
            Ain  = 1'b1;
          end
          OP_MVNZ: begin
            // A zero G turns the move into Rx <- Rx, leaving the register unchanged.
            Rin  = onehot(rx);
            Rout = (GRout != '0) ? onehot(ry) : onehot(rx);
            Done = 1'b1;
          end
          default: begin
            Done    = 1'b1;
            Illegal = 1'b1;
          end
        endcase
      end
      T2: begin
        Tstep = 2'd2;
        Rout  = onehot(ry);
        Gin   = 1'b1;
        Ulaop = alu_sel(op);
      end
      T3: begin
        Tstep = 2'd3;
        Gout  = 1'b1;
        Rin   = onehot(rx);
        Done  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_param.sv
// Scoreboard bench for unidade_controle_param: per-cycle expectations from an
// instruction-level model, checked by an independent negedge monitor.
module tb_unidade_controle_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT, default parameters (NREG=8, CNT_W=8, IW=9)
  logic        rst, run;
  logic [8:0]  ins;
  logic [15:0] gr;
  logic        irin, ain, gin, gout, dinout, done, illegal, busy;
  logic [7:0]  rin, rout, cnt;
  logic [1:0]  ulaop, tstep;

  unidade_controle_param dut (
    .Clock(clk), .Resetn(rst), .Run(run), .Instrucao(ins), .GRout(gr),
    .IRin(irin), .Rin(rin), .Rout(rout), .Ain(ain), .Gin(gin), .Gout(gout),
    .DINout(dinout), .Ulaop(ulaop), .Done(done), .Illegal(illegal),
    .Busy(busy), .Tstep(tstep), .InstrCount(cnt)
  );

  // Small DUT: NREG=4, CNT_W=2, IW=7
  logic        rst2, run2;
  logic [6:0]  ins2;
  logic [15:0] gr2;
  logic        irin2, ain2, gin2, gout2, dinout2, done2, illegal2, busy2;
  logic [3:0]  rin2, rout2;
  logic [1:0]  ulaop2, tstep2, cnt2;

  unidade_controle_param #(.NREG(4), .CNT_W(2)) dut2 (
    .Clock(clk), .Resetn(rst2), .Run(run2), .Instrucao(ins2), .GRout(gr2),
    .IRin(irin2), .Rin(rin2), .Rout(rout2), .Ain(ain2), .Gin(gin2), .Gout(gout2),
    .DINout(dinout2), .Ulaop(ulaop2), .Done(done2), .Illegal(illegal2),
    .Busy(busy2), .Tstep(tstep2), .InstrCount(cnt2)
  );

  typedef struct packed {
    logic       care;
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain, gin, gout, dinout;
    logic [1:0] ulaop;
    logic       done, illegal, busy;
    logic [1:0] tstep;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e, mon_a;
  int checks = 0;
  int errors = 0;
  int unsigned retired = 0;

  function automatic bit is_alu(input logic [2:0] op);
    return (op == 3'b010) || (op == 3'b011) || (op == 3'b110);
  endfunction

  // Expected outputs for step s of one instruction, straight from the ISA table
  function automatic exp_t expect_step(input logic [2:0] op, input int rx, input int ry,
                                       input logic [15:0] g, input int s, input int unsigned c);
    exp_t e;
    e = '0;
    e.care = 1'b1;
    e.busy = 1'b1;
    e.cnt = 8'(c);
    e.tstep = 2'(s);
    case (s)
      0: e.irin = 1'b1;
      1: case (op)
        3'b000: begin e.rin = 8'(1 << rx); e.rout = 8'(1 << ry); e.done = 1'b1; end
        3'b001: begin e.dinout = 1'b1; e.rin = 8'(1 << rx); e.done = 1'b1; end
        3'b100: begin
          e.rin = 8'(1 << rx);
          e.rout = (g != 16'h0) ? 8'(1 << ry) : 8'(1 << rx);
          e.done = 1'b1;
        end
        3'b010, 3'b011, 3'b110: begin e.rout = 8'(1 << rx); e.ain = 1'b1; end
        default: begin e.done = 1'b1; e.illegal = 1'b1; end
      endcase
      2: begin
        e.rout = 8'(1 << ry);
        e.gin = 1'b1;
        e.ulaop = (op == 3'b011) ? 2'b01 : (op == 3'b110) ? 2'b10 : 2'b00;
      end
      default: begin e.gout = 1'b1; e.rin = 8'(1 << rx); e.done = 1'b1; end
    endcase
    return e;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    e.care = 1'b1;
    e.cnt = 8'(retired);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic idle(input bit r);
    @(posedge clk); #1;
    rst = 1'b0; run = r; ins = 9'($urandom); gr = 16'($urandom);
    sb.push_back(idle_exp());
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      rst = 1'b1; run = 1'b1; ins = 9'($urandom); gr = 16'($urandom);
      if (i == 0) sb.push_back('0);
      else begin
        retired = 0;
        sb.push_back(idle_exp());
      end
    end
    retired = 0;
  endtask

  // One instruction; rst_at >= 0 asserts reset during that step and abandons it
  task automatic exec(input logic [2:0] op, input int rx, input int ry, input logic [15:0] g,
                      input bit run_last, input int rst_at);
    int n;
    n = is_alu(op) ? 4 : 2;
    for (int s = 0; s < n; s++) begin
      @(posedge clk); #1;
      rst = (s == rst_at);
      run = (s == n - 1) ? run_last : 1'($urandom);
      ins = (s == 0) ? 9'($urandom) : {op, 3'(rx), 3'(ry)};
      gr = (s == 1) ? g : 16'($urandom);
      sb.push_back(expect_step(op, rx, ry, g, s, retired));
      if (s == rst_at) begin
        retired = 0;
        return;
      end
    end
    retired++;
  endtask

  task automatic test_small();
    int rx, ry;
    repeat (2) @(posedge clk);
    #1; rst2 = 1'b0; run2 = 1'b1;
    @(negedge clk);
    chk("small_reset_busy", 32'(busy2), 32'd0);
    chk("small_reset_cnt", 32'(cnt2), 32'd0);
    for (int k = 0; k < 5; k++) begin
      rx = $urandom_range(0, 3);
      ry = $urandom_range(0, 3);
      @(posedge clk); #1; ins2 = 7'($urandom); gr2 = 16'($urandom);
      @(negedge clk);
      chk("small_t0_irin", 32'(irin2), 32'd1);
      @(posedge clk); #1; ins2 = {3'b000, 2'(rx), 2'(ry)}; run2 = (k < 4);
      @(negedge clk);
      chk("small_mv_rin", 32'(rin2), 32'(1 << rx));
      chk("small_mv_rout", 32'(rout2), 32'(1 << ry));
      chk("small_mv_done", 32'(done2), 32'd1);
      chk("small_cnt", 32'(cnt2), 32'(k % 4));
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("small_wrap_cnt", 32'(cnt2), 32'd1);
    chk("small_idle_busy", 32'(busy2), 32'd0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.care) begin
        mon_a = {1'b1, irin, rin, rout, ain, gin, gout, dinout, ulaop, done, illegal,
                 busy, tstep, cnt};
        checks++;
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL step_outputs t=%0t: got %h expected %h", $time, mon_a, mon_e);
        end
      end
    end
  end

  initial begin
    logic [2:0] op;
    int rx, ry, ra, n;
    logic [15:0] g;
    bit rl;
    rst = 1'b1; run = 1'b1; ins = '0; gr = '0;
    rst2 = 1'b1; run2 = 1'b0; ins2 = '0; gr2 = '0;

    test_small();

    do_reset();
    idle(1'b1);
    exec(3'b001, 3, 0, 16'h1234, 1'b1, -1);   // mvi R3
    exec(3'b000, 5, 3, 16'h0000, 1'b1, -1);   // mv R5,R3
    exec(3'b011, 2, 6, 16'h0007, 1'b1, -1);   // sub R2,R6
    exec(3'b010, 2, 6, 16'h0007, 1'b1, -1);   // add
    exec(3'b110, 2, 6, 16'h0007, 1'b1, -1);   // and
    exec(3'b100, 1, 4, 16'h0000, 1'b1, -1);   // mvnz, G zero
    exec(3'b100, 1, 4, 16'h0001, 1'b1, -1);   // mvnz, G nonzero
    exec(3'b111, 7, 7, 16'h0000, 1'b1, -1);   // illegal
    exec(3'b101, 0, 1, 16'h0000, 1'b1, -1);   // illegal
    exec(3'b010, 4, 5, 16'h0000, 1'b0, -1);   // add, Run dropped: finish then IDLE
    idle(1'b0);
    idle(1'b1);
    exec(3'b011, 2, 6, 16'h0000, 1'b1, 2);    // reset during T2 of sub
    idle(1'b1);

    // Long back-to-back run so the 8-bit counter wraps
    for (int k = 0; k < 260; k++)
      exec(3'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
           16'($urandom), 1'b1, -1);

    for (int k = 0; k < 300; k++) begin
      op = 3'($urandom_range(0, 7));
      rx = $urandom_range(0, 7);
      ry = $urandom_range(0, 7);
      g = $urandom_range(0, 1) ? 16'h0000 : 16'($urandom);
      rl = ($urandom_range(0, 3) != 0);
      n = is_alu(op) ? 4 : 2;
      ra = ($urandom_range(0, 29) == 0) ? $urandom_range(0, n - 1) : -1;
      exec(op, rx, ry, g, rl, ra);
      if (ra >= 0 || !rl) begin
        repeat ($urandom_range(0, 2)) idle(1'b0);
        idle(1'b1);
      end
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
